smoldvi_pattern_gen: RTL
========================

// Module: smoldvi_pattern_gen
//
// PURPOSE
//   Parametrised test-pattern source for the DVI pipeline. Walks an active-area raster
//   (H_ACTIVE_PIXELS x V_ACTIVE_LINES) one pixel per rgb_rdy and presents registered RGB.
//   Selectable modes: gradient, colour bars, checkerboard, solid, scrolling gradient.
//   Sits between the system and dvi_tx_parallel: r/g/b/rgb_rdy connect directly to it.
//
// PARAMETERS
//   H_ACTIVE_PIXELS  640  pixels per line; must be a multiple of 8, >= 16
//   V_ACTIVE_LINES   480  lines per frame; >= 2
//   W_COLOUR         8    bits per colour channel, 1..16
//   CHECK_LOG2       4    checkerboard square edge = 2**CHECK_LOG2 pixels
//
// PORTS
//   clk        in   1           pixel clock
//   rst_n      in   1           asynchronous active-low reset
//   en         in   1           0: hold raster at (0,0); 1: run
//   mode       in   3           pattern select, sampled at frame boundary only
//   solid_rgb  in   3*W_COLOUR  {r,g,b} colour for mode 3
//   rgb_rdy    in   1           consumer has taken the presented pixel this cycle
//   r,g,b      out  W_COLOUR    colour of presented pixel (registered)
//   sof        out  1           high while presented pixel is (0,0) (registered)
//   frame_ctr  out  8           completed-frame count, wraps 255->0
//
// BEHAVIOUR
// - Reset: x=0, y=0, frame_ctr=0, mode_q=0, bar_idx=0, bar_cnt=0, r=g=b=0, sof=1.
//   (0,0) in mode 0 with frame 0 is black, so reset state is consistent.
// - Presented pixel = (x,y) under mode_q. If en=1 and rgb_rdy=1, next cycle presents successor:
//   - x+1
//   - x wrap to 0 at H_ACTIVE_PIXELS-1, with y+1
//   - at (H-1,V-1): x=y=0, frame_ctr+1, mode_q<=mode
// - Latency: one cycle from rgb_rdy to the new pixel on r/g/b.
//   - Outputs computed from next-state counters and registered.
//   - No combinational path from rgb_rdy to r/g/b.
// - rgb_rdy is sampled every cycle; back-to-back rgb_rdy advances one pixel per cycle.
//   - rgb_rdy low: all state holds.
// - en=0:
//   - next cycle x=y=0, bar state cleared, mode_q<=mode; frame_ctr held; rgb_rdy ignored.
//   - Outputs present (0,0) of the sampled mode.
// - en deasserted mid-frame: raster restarts at (0,0) when en returns; no frame_ctr increment.
// - Mode change mid-frame: no effect until the frame boundary or en=0. No tearing.
// - Modes (ONES = all-ones W_COLOUR):
//   - 0 gradient:
//     - r = x[W_COLOUR-1:0], g = y[W_COLOUR-1:0]
//     - b = frame_ctr truncated or zero-extended to W_COLOUR
//   - 1 colour bars:
//     - 8 bars, each H/8 wide; bar_idx is tracked by a down-counter, no divider.
//     - r = ~bar_idx[1], g = ~bar_idx[2], b = ~bar_idx[0], each replicated to ONES/0.
//     - Bar order: white,yellow,cyan,green,magenta,red,blue,black.
//   - 2 checkerboard:
//     - c = x[CHECK_LOG2] ^ y[CHECK_LOG2]; r=g=b = c ? ONES : 0.
//     - (0,0) is black.
//   - 3 solid: {r,g,b} = solid_rgb; sampled live every pixel.
//   - 4 scroll:
//     - r = (x + frame_ctr)[W_COLOUR-1:0] modulo 2**W_COLOUR
//     - g = y[W_COLOUR-1:0], b = 0
//   - 5..7 reserved: r=g=b=0.
// - Counter widths: x $clog2(H_ACTIVE_PIXELS), y $clog2(V_ACTIVE_LINES).
//   Narrower colour truncates MSBs; wider zero-extends.
// - sof is high exactly while (x,y)=(0,0), including during reset and en=0.
//
// CONFIGURATION
//   SMOLDVI_PATGEN_BORDER_EN defined:
//     - Pixels with x=0, x=H-1, y=0 or y=V-1 output r=g=b=ONES in every mode, including reserved.
//     - At reset, r=g=b=ONES.
//   Undefined: no override; r=g=b=0 at reset. Everything else is identical.
//
// TESTING
// 1. Reset, en=1, rgb_rdy=1 constant, mode=0, 640x480:
//    - Cycle k shows x=k%640.
//    - After 307200 cycles: sof=1, frame_ctr=1, pixel (0,0) with b=1.
// 2. mode=1, rgb_rdy=1:
//    - x=0..79 gives FF/FF/FF; x=80 gives FF/FF/00; x=559 gives 00/00/FF; x=560..639 gives 00/00/00.
//    - Bars repeat identically on y=1.
// 3. rgb_rdy toggled randomly, mode=2:
//    - r/g/b change only in the cycle after rgb_rdy=1.
//    - x=16,y=0 gives FF; x=16,y=16 gives 00; the pixel sequence matches rgb_rdy=1 always.
// 4. mode 0->3 at (100,200):
//    - Gradient continues to end of frame.
//    - First pixel of the next frame equals solid_rgb=0x123456.
// 5. en low at (300,10) for 5 cycles, rgb_rdy=1:
//    - sof=1 while en=0; frame_ctr unchanged.
//    - Resumes at (0,0); frame completes 307200 pixels later.
// 6. With SMOLDVI_PATGEN_BORDER_EN, mode=5:
//    - (0,0), (639,5), (5,479) are FF; (1,1) is 00.
//    - Without the macro, all are 00.

Source files
------------

// File: rtl/smoldvi_pattern_gen_if.sv
// Pixel channel between the pattern source and the DVI transmitter.
// The source presents r/g/b; the consumer pulses rgb_rdy when it takes a pixel.
interface smoldvi_pattern_gen_if #(
    parameter int W_COLOUR = 8
);
    logic [W_COLOUR-1:0] r;
    logic [W_COLOUR-1:0] g;
    logic [W_COLOUR-1:0] b;
    logic                rgb_rdy;

    modport master (
        output r,
        output g,
        output b,
        input  rgb_rdy
    );

    modport slave (
        input  r,
        input  g,
        input  b,
        output rgb_rdy
    );
endinterface

// File: rtl/smoldvi_pattern_gen.sv
// Raster test-pattern source: gradient, bars, checker, solid, scroll.
// Define SMOLDVI_PATGEN_BORDER_EN to force a white one-pixel frame border.
module smoldvi_pattern_gen #(
    parameter int H_ACTIVE_PIXELS = 640,
    parameter int V_ACTIVE_LINES  = 480,
    parameter int W_COLOUR        = 8,
    parameter int CHECK_LOG2      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2:0]            mode,
    input  logic [3*W_COLOUR-1:0] solid_rgb,
    smoldvi_pattern_gen_if.master px,
    output logic                  sof,
    output logic [7:0]            frame_ctr
);
    localparam int XW    = $clog2(H_ACTIVE_PIXELS);
    localparam int YW    = $clog2(V_ACTIVE_LINES);
    localparam int BAR_W = H_ACTIVE_PIXELS / 8;
    localparam int BW    = $clog2(BAR_W);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE_LINES - 1);
    localparam logic [BW-1:0] BC_TOP = BW'(BAR_W - 1);
    localparam logic [BW-1:0] BC_ONE = BW'(1);

    localparam logic [W_COLOUR-1:0] ONES = '1;
`ifdef SMOLDVI_PATGEN_BORDER_EN
    localparam logic [W_COLOUR-1:0] RST_C = ONES;
`else
    localparam logic [W_COLOUR-1:0] RST_C = '0;
`endif

    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [7:0]    f_n;
    logic [2:0]    mode_q, m_n;
    logic [2:0]    bar_idx, bi_n;
    logic [BW-1:0] bar_cnt, bc_n;

    logic [W_COLOUR-1:0] r_n, g_n, b_n;
    logic                chk;

    // bar_cnt==0 marks the first pixel of a bar, then counts down to 1
    always_comb begin
        x_n  = x;
        y_n  = y;
        f_n  = frame_ctr;
        m_n  = mode_q;
        bi_n = bar_idx;
        bc_n = bar_cnt;
        if (!en) begin
            x_n  = '0;
            y_n  = '0;
            m_n  = mode;
            bi_n = '0;
            bc_n = '0;
        end else if (px.rgb_rdy) begin
            if (x == X_LAST) begin
                x_n  = '0;
                bi_n = '0;
                bc_n = '0;
                if (y == Y_LAST) begin
                    y_n = '0;
                    f_n = frame_ctr + 8'd1;
                    m_n = mode;
                end else begin
                    y_n = y + 1'b1;
                end
            end else begin
                x_n = x + 1'b1;
                if (bar_cnt == BC_ONE) begin
                    bi_n = bar_idx + 3'd1;
                    bc_n = '0;
                end else if (bar_cnt == '0) begin
                    bc_n = BC_TOP;
                end else begin
                    bc_n = bar_cnt - 1'b1;
                end
            end
        end
    end

    assign chk = x_n[CHECK_LOG2] ^ y_n[CHECK_LOG2];

    // Colour is derived from the successor pixel so r/g/b land with it
    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        case (m_n)
            3'd0: begin
                r_n = W_COLOUR'(x_n);
                g_n = W_COLOUR'(y_n);
                b_n = W_COLOUR'(f_n);
            end
            3'd1: begin
                r_n = {W_COLOUR{~bi_n[1]}};
                g_n = {W_COLOUR{~bi_n[2]}};
                b_n = {W_COLOUR{~bi_n[0]}};
            end
            3'd2: begin
                r_n = chk ? ONES : '0;
                g_n = chk ? ONES : '0;
                b_n = chk ? ONES : '0;
            end
            3'd3: begin
                {r_n, g_n, b_n} = solid_rgb;
            end
            3'd4: begin
                r_n = W_COLOUR'(x_n) + W_COLOUR'(f_n);
                g_n = W_COLOUR'(y_n);
            end
            default: begin
                r_n = '0;
            end
        endcase
`ifdef SMOLDVI_PATGEN_BORDER_EN
        if (x_n == '0 || x_n == X_LAST ||
            y_n == '0 || y_n == Y_LAST) begin
            r_n = ONES;
            g_n = ONES;
            b_n = ONES;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            frame_ctr <= '0;
            mode_q    <= '0;
            bar_idx   <= '0;
            bar_cnt   <= '0;
            px.r      <= RST_C;
            px.g      <= RST_C;
            px.b      <= RST_C;
            sof       <= 1'b1;
        end else begin
            x         <= x_n;
            y         <= y_n;
            frame_ctr <= f_n;
            mode_q    <= m_n;
            bar_idx   <= bi_n;
            bar_cnt   <= bc_n;
            px.r      <= r_n;
            px.g      <= g_n;
            px.b      <= b_n;
            sof       <= (x_n == '0) && (y_n == '0);
        end
    end
endmodule
